// File: rtl/ppu_mem_pkg.sv
// Shared types for the PPU RAM arbiter: FSM states, grant owner and the
// CPU mask to memory byte-enable conversion.
package ppu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_ACK  = 2'd2,
    ACK     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_VID  = 2'd2
  } gnt_t;

  // CPU mask bit 1 means "do not write this byte"; memory wants 1 = write.
  function automatic logic [3:0] mask_to_be(input logic [3:0] mask);
    return ~mask;
  endfunction

endpackage

// File: rtl/ppu_ram_arb.sv
// Single-port RAM arbiter between the PPU CPU port and the video scanout
// fetch port. Video has priority; a starvation counter forces a CPU grant
// after VID_MAX consecutive video grants while the CPU waits.
module ppu_ram_arb
  import ppu_mem_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned VID_MAX = 4
) (
  input  logic          clk_ppu_p,
  input  logic          vm_init,
  input  logic [AW-1:0] addr_ram,
  input  logic [31:0]   duot_ram,
  input  logic [3:0]    mask_ram,
  input  logic          read_ram,
  input  logic          wrte_ram,
  output logic          askn_ram,
  output logic [31:0]   dinp_ram,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [31:0]   vid_dat,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned SW         = $clog2(VID_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(VID_MAX);
  localparam logic [2:0]    LAT_LAST   = 3'(RD_LAT);

  state_t        state_q, state_d;
  gnt_t          gnt_q, gnt_d;
  logic [2:0]    lat_q, lat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          cpu_done_q, cpu_done_d;

  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_re_q, mem_re_d;
  logic          askn_q, askn_d;
  logic          vid_ack_q, vid_ack_d;
  logic [31:0]   dinp_q, dinp_d;
  logic [31:0]   vid_dat_q, vid_dat_d;

  logic cpu_req;
  logic cpu_pend;

  assign cpu_req  = read_ram | wrte_ram;
  assign cpu_pend = cpu_req & ~cpu_done_q;

  // Arbitration, access sequencing, starvation tracking and ack generation.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    cpu_done_d  = cpu_done_q;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_be_d    = '0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    askn_d      = 1'b0;
    vid_ack_d   = 1'b0;
    dinp_d      = dinp_q;
    vid_dat_d   = vid_dat_q;

    if (!cpu_req) cpu_done_d = 1'b0;
    if (!cpu_pend) starve_d = '0;

    unique case (state_q)
      IDLE: begin
        if (vid_req && !(cpu_pend && starve_q == STARVE_MAX)) begin
          gnt_d      = GNT_VID;
          mem_re_d   = 1'b1;
          mem_addr_d = vid_addr;
          lat_d      = '0;
          state_d    = RD_WAIT;
          // Only reachable below STARVE_MAX while the CPU waits, so no wrap.
          if (cpu_pend) starve_d = starve_q + 1'b1;
        end else if (cpu_pend) begin
          gnt_d      = GNT_CPU;
          starve_d   = '0;
          mem_addr_d = addr_ram;
          lat_d      = '0;
          if (wrte_ram) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = duot_ram;
            mem_be_d    = mask_to_be(mask_ram);
            state_d     = WR_ACK;
          end else begin
            mem_re_d = 1'b1;
            state_d  = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          if (gnt_q == GNT_CPU) begin
            dinp_d = mem_rdata;
            if (cpu_req) begin
              askn_d     = 1'b1;
              cpu_done_d = 1'b1;
            end
          end else begin
            vid_dat_d = mem_rdata;
            vid_ack_d = 1'b1;
          end
          state_d = ACK;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      WR_ACK: begin
        if (cpu_req) begin
          askn_d     = 1'b1;
          cpu_done_d = 1'b1;
        end
        state_d = ACK;
      end
      ACK: begin
        gnt_d   = GNT_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset discards any in-flight access.
  always_ff @(posedge clk_ppu_p) begin
    if (vm_init) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_NONE;
      lat_q       <= '0;
      starve_q    <= '0;
      cpu_done_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      askn_q      <= 1'b0;
      vid_ack_q   <= 1'b0;
      dinp_q      <= '0;
      vid_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      cpu_done_q  <= cpu_done_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      askn_q      <= askn_d;
      vid_ack_q   <= vid_ack_d;
      dinp_q      <= dinp_d;
      vid_dat_q   <= vid_dat_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign askn_ram  = askn_q;
  assign vid_ack   = vid_ack_q;
  assign dinp_ram  = dinp_q;
  assign vid_dat   = vid_dat_q;

endmodule

// File: tb/tb_ppu_ram_arb.sv
// Directed bench for ppu_ram_arb: u_dut uses RD_LAT=1, u_dut2 uses RD_LAT=2.
// Each DUT has its own behavioural RAM; words default to {addr, ~addr}.
module tb_ppu_ram_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] addr, vaddr, addr2;
  logic [31:0] wdat;
  logic [3:0]  mask;
  logic        rd, wr, vreq, rd2;

  logic        askn, vack, mwe, mre;
  logic [31:0] dinp, vdat, mwdata, mrdata;
  logic [15:0] maddr;
  logic [3:0]  mbe;

  logic        askn2, vack2, mwe2, mre2;
  logic [31:0] dinp2, vdat2, mwdata2, mrdata2;
  logic [15:0] maddr2;
  logic [3:0]  mbe2;

  int n_cmp = 0;
  int n_err = 0;

  ppu_ram_arb #(.AW(16), .RD_LAT(1), .VID_MAX(4)) u_dut (
    .clk_ppu_p(clk), .vm_init(rst),
    .addr_ram(addr), .duot_ram(wdat), .mask_ram(mask),
    .read_ram(rd), .wrte_ram(wr), .askn_ram(askn), .dinp_ram(dinp),
    .vid_req(vreq), .vid_addr(vaddr), .vid_ack(vack), .vid_dat(vdat),
    .mem_addr(maddr), .mem_wdata(mwdata), .mem_be(mbe),
    .mem_we(mwe), .mem_re(mre), .mem_rdata(mrdata)
  );

  ppu_ram_arb #(.AW(16), .RD_LAT(2), .VID_MAX(4)) u_dut2 (
    .clk_ppu_p(clk), .vm_init(rst),
    .addr_ram(addr2), .duot_ram(32'h0), .mask_ram(4'h0),
    .read_ram(rd2), .wrte_ram(1'b0), .askn_ram(askn2), .dinp_ram(dinp2),
    .vid_req(1'b0), .vid_addr(16'h0), .vid_ack(vack2), .vid_dat(vdat2),
    .mem_addr(maddr2), .mem_wdata(mwdata2), .mem_be(mbe2),
    .mem_we(mwe2), .mem_re(mre2), .mem_rdata(mrdata2)
  );

  // RAM model for u_dut, latency 1; data bus is junk outside the valid cycle.
  logic [31:0] mem1 [0:65535];
  logic        rv1;
  logic [31:0] rq1;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 65536; i++) mem1[i] <= {16'(i), ~16'(i)};
      rv1 <= 1'b0;
    end else begin
      rv1 <= mre;
      if (mre) rq1 <= mem1[maddr];
      if (mwe)
        for (int b = 0; b < 4; b++)
          if (mbe[b]) mem1[maddr][8*b +: 8] <= mwdata[8*b +: 8];
    end
  end
  assign mrdata = rv1 ? rq1 : 32'hDEADBEEF;

  // RAM model for u_dut2, latency 2.
  logic [31:0] mem2 [0:65535];
  logic        rv2a, rv2b;
  logic [31:0] rq2a, rq2b;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 65536; i++) mem2[i] <= {16'(i), ~16'(i)};
      mem2[16'h0040] <= 32'h0123_4567;
      rv2a <= 1'b0;
      rv2b <= 1'b0;
    end else begin
      rv2a <= mre2;
      rv2b <= rv2a;
      if (mre2) rq2a <= mem2[maddr2];
      rq2b <= rq2a;
    end
  end
  assign mrdata2 = rv2b ? rq2b : 32'hDEADBEEF;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; addr = '0; vaddr = '0; addr2 = '0; wdat = '0; mask = '0;
    rd = 1'b0; wr = 1'b0; vreq = 1'b0; rd2 = 1'b0;
    step(); step();
    // Reset state
    chk("rst_askn", 32'(askn), 32'd0);
    chk("rst_vack", 32'(vack), 32'd0);
    chk("rst_mwe", 32'(mwe), 32'd0);
    chk("rst_mre", 32'(mre), 32'd0);
    chk("rst_maddr", 32'(maddr), 32'd0);
    chk("rst_dinp", dinp, 32'd0);
    chk("rst_vdat", vdat, 32'd0);
    rst = 1'b0;
    step(); step();

    // CPU write, cycle T
    addr = 16'h1234; wdat = 32'hAABBCCDD; mask = 4'b1100; wr = 1'b1;
    step(); // T+1
    chk("wr_mwe", 32'(mwe), 32'd1);
    chk("wr_mre", 32'(mre), 32'd0);
    chk("wr_mbe", 32'(mbe), 32'h3);
    chk("wr_maddr", 32'(maddr), 32'h1234);
    chk("wr_mwdata", mwdata, 32'hAABBCCDD);
    chk("wr_askn_t1", 32'(askn), 32'd0);
    step(); // T+2
    chk("wr_askn_t2", 32'(askn), 32'd1);
    chk("wr_mwe_t2", 32'(mwe), 32'd0);
    wr = 1'b0; mask = 4'b0000;
    step(); // T+3
    chk("wr_askn_t3", 32'(askn), 32'd0);

    // CPU read on RD_LAT=2 instance
    addr2 = 16'h0040; rd2 = 1'b1;
    step(); // T+1
    chk("rd2_mre", 32'(mre2), 32'd1);
    chk("rd2_maddr", 32'(maddr2), 32'h0040);
    step(); // T+2
    chk("rd2_askn_t2", 32'(askn2), 32'd0);
    step(); // T+3
    chk("rd2_askn_t3", 32'(askn2), 32'd0);
    step(); // T+4
    chk("rd2_askn_t4", 32'(askn2), 32'd1);
    chk("rd2_dinp", dinp2, 32'h0123_4567);
    rd2 = 1'b0;
    step(); // T+5
    chk("rd2_askn_t5", 32'(askn2), 32'd0);
    chk("rd2_dinp_hold", dinp2, 32'h0123_4567);
    step();

    // Read back the partially written word; hold read_ram after the ack
    addr = 16'h1234; rd = 1'b1;
    step(); // T+1
    chk("rb_mre", 32'(mre), 32'd1);
    step(); // T+2
    chk("rb_askn_t2", 32'(askn), 32'd0);
    step(); // T+3
    chk("rb_askn_t3", 32'(askn), 32'd1);
    chk("rb_dinp", dinp, 32'h1234_CCDD);
    step(); // T+4
    chk("hold_askn_t4", 32'(askn), 32'd0);
    step(); // T+5
    chk("hold_askn_t5", 32'(askn), 32'd0);
    chk("hold_mre_t5", 32'(mre), 32'd0);
    rd = 1'b0;
    step(); // T+6
    chk("hold_mre_t6", 32'(mre), 32'd0);
    step(); // T+7
    chk("hold_mre_t7", 32'(mre), 32'd0);
    chk("hold_askn_t7", 32'(askn), 32'd0);
    addr = 16'h1235; rd = 1'b1;
    step();
    chk("rerd_mre", 32'(mre), 32'd1);
    chk("rerd_maddr", 32'(maddr), 32'h1235);
    step(); step();
    chk("rerd_askn", 32'(askn), 32'd1);
    chk("rerd_dinp", dinp, 32'h1235_EDCA);
    rd = 1'b0;
    step();

    // Video only: one ack every 4 cycles
    vreq = 1'b1; vaddr = 16'h0100;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("vid_mre", 32'(mre), 32'd1);
      chk("vid_maddr", 32'(maddr), 32'(16'h0100 + k));
      chk("vid_ack_s1", 32'(vack), 32'd0);
      step();
      chk("vid_ack_s2", 32'(vack), 32'd0);
      step();
      chk("vid_ack_s3", 32'(vack), 32'd1);
      chk("vid_dat", vdat, {16'h0100 + 16'(k), ~(16'h0100 + 16'(k))});
      if (k == 3) vreq = 1'b0;
      else vaddr = 16'h0100 + 16'(k + 1);
      step();
    end
    chk("vid_idle_mre", 32'(mre), 32'd0);
    step();

    // Contention: V,V,V,V,C,V,V,V,V,C
    vreq = 1'b1; vaddr = 16'h0200; rd = 1'b1; addr = 16'h0040;
    for (int g = 0; g < 10; g++) begin
      rd = 1'b1;
      step();
      chk("cont_mre", 32'(mre), 32'd1);
      chk("cont_owner", 32'(maddr), (g == 4 || g == 9) ? 32'h0040 : 32'h0200);
      step();
      step();
      if (g == 4 || g == 9) begin
        chk("cont_askn", 32'(askn), 32'd1);
        chk("cont_dinp", dinp, 32'h0040_FFBF);
        rd = 1'b0;
      end else begin
        chk("cont_vack", 32'(vack), 32'd1);
        chk("cont_askn_v", 32'(askn), 32'd0);
      end
      if (g == 9) vreq = 1'b0;
      step();
    end
    rd = 1'b0;
    step(); step();

    // Read and write together count as a write
    addr = 16'h0050; wdat = 32'h11223344; mask = 4'b0000; rd = 1'b1; wr = 1'b1;
    step();
    chk("rw_mwe", 32'(mwe), 32'd1);
    chk("rw_mre", 32'(mre), 32'd0);
    chk("rw_mbe", 32'(mbe), 32'hF);
    step();
    chk("rw_askn", 32'(askn), 32'd1);
    rd = 1'b0; wr = 1'b0;
    step(); step();

    // Reset in the cycle after mem_re aborts the read
    addr = 16'h1234; rd = 1'b1;
    step(); // T+1
    chk("rstrd_mre", 32'(mre), 32'd1);
    step(); // T+2
    rst = 1'b1; rd = 1'b0;
    step(); // T+3
    chk("rstrd_askn", 32'(askn), 32'd0);
    chk("rstrd_vack", 32'(vack), 32'd0);
    chk("rstrd_dinp", dinp, 32'd0);
    chk("rstrd_vdat", vdat, 32'd0);
    rst = 1'b0;
    step();
    chk("rstrd_askn2", 32'(askn), 32'd0);
    step();
    addr = 16'h0041; rd = 1'b1;
    step();
    chk("post_mre", 32'(mre), 32'd1);
    step(); step();
    chk("post_askn", 32'(askn), 32'd1);
    chk("post_dinp", dinp, 32'h0041_FFBE);
    rd = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ppu_ram_arb.md
Name: ppu_ram_arb

Overview:
- Downstream neighbour of the PPU CPU Wishbone wrapper. Consumes its RAM request port and returns the acknowledge and read data.
- Arbitrates that CPU port against the video scanout fetch port for one single-port synchronous memory: 32-bit words, 16-bit word address, byte enables, fixed read latency.
- Video is hard real-time and normally has priority. A starvation guard guarantees CPU progress.

Parameters:
- AW, 16, word address width.
- RD_LAT, 1, memory read latency in clocks (1..4): mem_re cycle to mem_rdata valid.
- VID_MAX, 4, max consecutive video grants while a CPU request waits.

Ports:
- clk_ppu_p  in  1  sole clock, all logic on rising edge.
- vm_init  in  1  synchronous active-high reset.
- addr_ram  in  AW  CPU word address.
- duot_ram  in  32  CPU write data.
- mask_ram  in  4  CPU byte mask; 1 = byte NOT written.
- read_ram  in  1  CPU read request (level, held until ack).
- wrte_ram  in  1  CPU write request (level, held until ack).
- askn_ram  out  1  CPU ack, one-cycle pulse.
- dinp_ram  out  32  CPU read data.
- vid_req  in  1  video fetch request (level).
- vid_addr  in  AW  video word address.
- vid_ack  out  1  video ack pulse.
- vid_dat  out  32  video read data.
- mem_addr  out  AW  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enable; 1 = write byte.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_rdata  in  32  memory read data.

Behaviour:
- Clock and reset: one clock, clk_ppu_p; reset vm_init is synchronous and active-high.
- Reset values: all outputs 0 (askn_ram, vid_ack, mem_we, mem_re, mem_addr, mem_wdata, mem_be, dinp_ram, vid_dat). State IDLE, starve counter 0, cpu_done 0.
  - Reset mid-operation aborts any in-flight read: no ack is issued and captured data is discarded.
- States: IDLE, RD_WAIT, WR_ACK, ACK.
- IDLE, sampled at cycle T:
  - Pending requests: cpu_pend = (read_ram | wrte_ram) & ~cpu_done; vid_pend = vid_req.
  - Grant video if vid_pend & ~(cpu_pend & starve == VID_MAX); otherwise grant CPU if cpu_pend.
- Issue: all mem_* outputs are registered and driven at T+1 for exactly one cycle.
  - Video: mem_re=1, mem_addr=vid_addr.
  - CPU read: mem_re=1, mem_addr=addr_ram; mask ignored.
  - CPU write: mem_we=1, mem_addr=addr_ram, mem_wdata=duot_ram, mem_be=~mask_ram.
  - read_ram and wrte_ram both high: treat as write.
- Read latency: RD_WAIT counts RD_LAT cycles; mem_rdata is captured at T+1+RD_LAT.
  - CPU read: dinp_ram is registered and askn_ram pulses at T+2+RD_LAT. Video read: vid_dat and vid_ack at the same point.
  - dinp_ram and vid_dat hold their value until the next completed read for that port.
- Write: WR_ACK; askn_ram pulses at T+2.
- ACK: one cycle, then back to IDLE; the next arbitration is in the cycle after the ack pulse.
  - Sustained throughput is one access per 3+RD_LAT cycles.
- cpu_done:
  - Set with the CPU askn pulse; cleared when read_ram and wrte_ram are both low.
  - Blocks re-service of a request still held during the CPU's ack-acceptance cycle.
- Starve counter:
  - Increments on each video grant made while cpu_pend=1.
  - Clears on every CPU grant and whenever cpu_pend=0.
  - Saturates at VID_MAX.
- CPU request dropped before its ack (wrapper strobe loss): the access already issued completes to memory. No ack is issued if the request is low at the ack cycle; dinp_ram is still updated.
- vid_req dropped mid-access: the access completes and vid_ack still pulses; the video side ignores it.
- Address wrap: none. Addresses pass through unmodified, and AW bits cover the full space.

Decomposition:
- Package ppu_mem_pkg holds:
  - state enum (IDLE, RD_WAIT, WR_ACK, ACK);
  - grant-owner encoding (GNT_NONE, GNT_CPU, GNT_VID);
  - mask-to-byte-enable helper.
- No sub-module: the arbiter, latency counter and starve counter are one FSM, about 200 lines.

Test Plan:
- CPU write, RD_LAT=1: addr 0x1234, data 0xAABBCCDD, mask 4'b1100 -> mem_we=1 one cycle at T+1, mem_be=4'b0011, mem_addr 0x1234; askn_ram single pulse at T+2.
- CPU read: memory word 0x0123_4567 at 0x0040, RD_LAT=2 -> mem_re at T+1; dinp_ram=0x01234567 with askn pulse at T+4; dinp_ram holds after read_ram drops.
- Contention: vid_req and read_ram both high continuously, VID_MAX=4 -> grant order V,V,V,V,C,V,V,V,V,C; no CPU wait exceeds 4 video accesses.
- Held request: read_ram stays high 2 cycles after ack -> exactly one askn pulse; a new read is served only after read_ram goes low then high.
- Reset mid-read: vm_init asserted at the cycle after mem_re -> no askn, no vid_ack; dinp_ram=0; the next request is served normally.
- Video only: vid_req held high, addresses 0x100, 0x101, ... -> one vid_ack per 4 cycles (RD_LAT=1), vid_dat matches memory at each address.
